div_seq: RTL

Multi-cycle divider sequencer used by the EX stage for DIV/DIVU. EX issues a start with operands and holds it. div_seq runs a 32-iteration restoring division FSM, then presents {remainder, quotient} as a registered 64-bit result for the HI/LO write path. EX uses busy_o to raise its pipeline stall request.

---
 rtl/div_seq_pkg.sv | 31 +++
 rtl/div_seq_if.sv | 35 +++
 rtl/div_seq_step.sv | 30 +++
 rtl/div_seq.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// ============================================================================
// Module   : div_seq_pkg
// Purpose  : Shared state encodings, flag values and sizing helper for div_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_seq_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Iteration counter width: one iteration per operand bit.
  function automatic int div_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_seq_if.sv
// ============================================================================
// Module   : div_seq_if
// Purpose  : EX-stage <-> divider handshake bundle (request, operands, result).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_seq_if
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
);

  logic                  start_i;
  logic                  annul_i;
  logic                  signed_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  busy_o;

  modport master (
    output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/div_seq_step.sv
// ============================================================================
// Module   : div_seq_step
// Purpose  : One restoring-division iteration: shift in a dividend bit, trial
//            subtract the divisor, keep or restore the partial remainder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_in,
  input  logic              dvd_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W:0]   rem_out,
  output logic              q_bit
);

  logic [DATA_W+1:0] shifted;
  logic [DATA_W+1:0] diff;

  // One guard bit above the remainder so the borrow shows up as the MSB.
  assign shifted = {rem_in, dvd_bit};
  assign diff    = shifted - {2'b00, divisor};
  assign q_bit   = ~diff[DATA_W+1];
  assign rem_out = q_bit ? diff[DATA_W:0] : shifted[DATA_W:0];

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// Module   : div_seq
// Purpose  : Multi-cycle DIV/DIVU sequencer; {remainder, quotient} for HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam int CNT_W = div_cnt_w(DATA_W);

  div_state_e            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DATA_W:0]       rem, rem_n;
  logic [DATA_W-1:0]     dvd, dvd_n;
  logic [DATA_W-1:0]     dvs, dvs_n;
  logic [DATA_W-1:0]     quot, quot_n;
  logic                  q_neg, q_neg_n;
  logic                  r_neg, r_neg_n;
  logic [2*DATA_W-1:0]   result, result_n;
  logic                  ready, ready_n;

  logic [DATA_W:0]       step_rem;
  logic                  step_q;
  logic [DATA_W-1:0]     q_fin, r_fin, q_sgn, r_sgn;

  div_seq_step #(.DATA_W(DATA_W)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[DATA_W-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign q_fin = {quot[DATA_W-2:0], step_q};
  assign r_fin = step_rem[DATA_W-1:0];
  assign q_sgn = q_neg ? -q_fin : q_fin;
  assign r_sgn = r_neg ? -r_fin : r_fin;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    dvd_n    = dvd;
    dvs_n    = dvs;
    quot_n   = quot;
    q_neg_n  = q_neg;
    r_neg_n  = r_neg;
    result_n = result;
    ready_n  = ready;
    case (state)
      DIV_FREE: begin
        if (bus.start_i == DIV_START && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_n = DIV_BY_ZERO;
          end else begin
            // Negation of the most negative value wraps to itself, which is
            // exactly its unsigned magnitude.
            dvd_n   = (bus.signed_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
            dvs_n   = (bus.signed_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
            q_neg_n = bus.signed_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
            r_neg_n = bus.signed_i & bus.opdata1_i[DATA_W-1];
            rem_n   = '0;
            quot_n  = '0;
            cnt_n   = '0;
            state_n = DIV_ON;
          end
        end
      end
      DIV_BY_ZERO: begin
        result_n = '0;
        ready_n  = DIV_RESULT_READY;
        state_n  = DIV_END;
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          state_n = DIV_FREE;
        end else begin
          rem_n  = step_rem;
          dvd_n  = {dvd[DATA_W-2:0], 1'b0};
          quot_n = q_fin;
          cnt_n  = cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W-1)) begin
            result_n = {r_sgn, q_sgn};
            ready_n  = DIV_RESULT_READY;
            state_n  = DIV_END;
          end
        end
      end
      DIV_END: begin
        if (bus.start_i == DIV_STOP || bus.annul_i) begin
          result_n = '0;
          ready_n  = DIV_RESULT_NOT_READY;
          state_n  = DIV_FREE;
        end
      end
      default: state_n = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DIV_FREE;
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      quot   <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= '0;
      ready  <= DIV_RESULT_NOT_READY;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rem    <= rem_n;
      dvd    <= dvd_n;
      dvs    <= dvs_n;
      quot   <= quot_n;
      q_neg  <= q_neg_n;
      r_neg  <= r_neg_n;
      result <= result_n;
      ready  <= ready_n;
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
  assign bus.busy_o   = (state == DIV_ON) || (state == DIV_BY_ZERO);

endmodule

`default_nettype wire
